// File: rtl/mini_alu_seq.sv
// Sequential mini ALU: single-cycle logic/arith ops, shift-add multiply, valid/ready
// handshake on both sides, accumulator operand source and an LED mirror of the last result.
module mini_alu_seq #(
  parameter int WIDTH = 8,
  parameter int LED_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ctrl,
  input  logic             acc_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [LED_W-1:0] LED
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     op_a, op_b;
  logic [2*WIDTH-1:0]   prod, prod_nxt, partial;
  logic [SW-1:0]        cnt;
  logic                 mul_last;
  logic [WIDTH-1:0]     opa_in;
  logic [WIDTH+3:0]     alu_out;

  // Returns {N,Z,C,V,result} for every opcode except MUL.
  function automatic logic [WIDTH+3:0] alu(input logic [2:0] c,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   wide;
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] r;
    logic             cf, vf;
    logic [SW-1:0]    amt;
    amt  = b[SW-1:0];
    wide = '0;
    sh   = '0;
    r    = '0;
    cf   = 1'b0;
    vf   = 1'b0;
    case (c)
      3'b000: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[WIDTH-1:0];
        cf   = wide[WIDTH];
        vf   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        r  = a - b;
        cf = a < b;
        vf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      // The extra guard bit catches the last bit shifted out; it stays 0 for amount 0.
      3'b101: begin
        sh = {1'b0, a} << amt;
        r  = sh[WIDTH-1:0];
        cf = sh[WIDTH];
      end
      3'b110: begin
        sh = {a, 1'b0} >> amt;
        r  = sh[WIDTH:1];
        cf = sh[0];
      end
      default: r = '0;
    endcase
    return {r[WIDTH-1], (r == '0), cf, vf, r};
  endfunction

  assign opa_in    = acc_mode ? acc : A;
  assign alu_out   = alu(ctrl, opa_in, B);
  assign partial   = op_b[cnt] ? ({{WIDTH{1'b0}}, op_a} << cnt) : '0;
  assign prod_nxt  = prod + partial;
  assign mul_last  = (cnt == SW'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (ctrl == OP_MUL) ? MUL : DONE;
      MUL:     if (mul_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      flags  <= '0;
      LED    <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          cnt <= '0;
          if (ctrl != OP_MUL) begin
            result <= alu_out[WIDTH-1:0];
            flags  <= alu_out[WIDTH+3:WIDTH];
            LED    <= alu_out[LED_W-1:0];
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (mul_last) begin
            result <= prod_nxt[WIDTH-1:0];
            flags  <= {prod_nxt[WIDTH-1], (prod_nxt[WIDTH-1:0] == '0),
                       (|prod_nxt[2*WIDTH-1:WIDTH]), 1'b0};
            LED    <= prod_nxt[LED_W-1:0];
          end
        end
        DONE: if (out_ready) acc <= result;
        default: ;
      endcase
    end
  end

  // Operand and partial-product registers are pure datapath and need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      op_a <= opa_in;
      op_b <= B;
      prod <= '0;
    end else if (state == MUL) begin
      prod <= prod_nxt;
    end
  end

endmodule

// File: tb/tb_mini_alu_seq.sv
// Directed bench for mini_alu_seq (WIDTH=8, LED_W=4) with hand-computed expectations.
module tb_mini_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, acc_mode, out_valid, out_ready;
  logic [7:0] A, B, result;
  logic [2:0] ctrl;
  logic [3:0] flags;
  logic [3:0] LED;

  int tests = 0;
  int fails = 0;
  int lat;
  logic busy_ok;
  logic hold_ok;

  mini_alu_seq #(.WIDTH(8), .LED_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ctrl(ctrl), .acc_mode(acc_mode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags), .LED(LED)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request (caller ensures in_ready) and wait, bounded, for out_valid.
  task automatic run_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                        input logic am);
    ctrl = c; A = a; B = b; acc_mode = am; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; acc_mode = 1'b0;
    A = '0; B = '0; ctrl = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 8'h00);
    chk("rst_flags", flags, 4'h0);
    chk("rst_led", LED, 4'h0);
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    // Accumulator chain from reset value 0.
    run_op(3'b000, 8'h00, 8'h03, 1'b1);
    chk("acc1", result, 8'h03);
    handshake();
    run_op(3'b000, 8'h00, 8'h03, 1'b1);
    chk("acc2", result, 8'h06);
    handshake();
    run_op(3'b000, 8'h00, 8'h03, 1'b1);
    chk("acc3", result, 8'h09);
    chk("acc3_led", LED, 4'h9);
    handshake();
    chk("after_hs_in_ready", in_ready, 1);
    chk("after_hs_out_valid", out_valid, 0);
    chk("led_hold_idle", LED, 4'h9);

    run_op(3'b000, 8'h7F, 8'h01, 1'b0);
    chk("add_lat", lat, 1);
    chk("add_res", result, 8'h80);
    chk("add_flags", flags, 4'b1001);
    chk("add_led", LED, 4'h0);
    handshake();

    run_op(3'b001, 8'h05, 8'h06, 1'b0);
    chk("sub_res", result, 8'hFF);
    chk("sub_flags", flags, 4'b1010);
    handshake();

    run_op(3'b010, 8'hAA, 8'h55, 1'b0);
    chk("and_res", result, 8'h00);
    chk("and_flags", flags, 4'b0100);
    handshake();

    run_op(3'b011, 8'h0F, 8'h30, 1'b0);
    chk("or_res", result, 8'h3F);
    chk("or_flags", flags, 4'b0000);
    handshake();

    run_op(3'b101, 8'h81, 8'h01, 1'b0);
    chk("shl_res", result, 8'h02);
    chk("shl_flags", flags, 4'b0010);
    handshake();

    run_op(3'b110, 8'h81, 8'h01, 1'b0);
    chk("shr_res", result, 8'h40);
    chk("shr_flags", flags, 4'b0010);
    handshake();

    run_op(3'b110, 8'h81, 8'h08, 1'b0);
    chk("shr0_res", result, 8'h81);
    chk("shr0_flags", flags, 4'b1000);
    handshake();

    run_op(3'b111, 8'h10, 8'h11, 1'b0);
    chk("mul_lat", lat, 9);
    chk("mul_busy", busy_ok, 1);
    chk("mul_res", result, 8'h10);
    chk("mul_flags", flags, 4'b0010);
    handshake();

    // Backpressure: hold out_ready low while a second request waits on in_valid.
    run_op(3'b100, 8'h0F, 8'hF0, 1'b0);
    chk("xor_res", result, 8'hFF);
    chk("xor_led", LED, 4'hF);
    ctrl = 3'b000; A = 8'h01; B = 8'h02; acc_mode = 1'b0; in_valid = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!(out_valid && !in_ready && result == 8'hFF && flags == 4'b1000)) hold_ok = 1'b0;
    end
    chk("bp_hold", hold_ok, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_res", result, 8'h03);
    handshake();

    // Reset during the 4th MUL cycle.
    ctrl = 3'b111; A = 8'h23; B = 8'h45; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_result", result, 8'h00);
    chk("mrst_flags", flags, 4'h0);
    chk("mrst_led", LED, 4'h0);
    rst_n = 1'b1;
    chk("mrst_in_ready", in_ready, 1);
    run_op(3'b000, 8'h00, 8'h01, 1'b1);
    chk("mrst_acc_add", result, 8'h01);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mini_alu_seq.md
MINI_ALU_SEQ -- requirements
Module: mini_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (>=4, power of 2).
REQ-002 SHALL have parameter LED_W, default 4, LED mirror width (<=WIDTH).
REQ-003 SHALL have one clock; reset is synchronous and active-low: clk and rst_n.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  operation request.
REQ-007 SHALL have port in_ready  output  1  block accepts request.
REQ-008 SHALL have port A  input  WIDTH  operand A.
REQ-009 SHALL have port B  input  WIDTH  operand B.
REQ-010 SHALL have port ctrl  input  3  opcode.
REQ-011 SHALL have port acc_mode  input  1  use accumulator instead of A.
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  consumer takes result.
REQ-014 SHALL have port result  output  WIDTH  registered result.
REQ-015 SHALL have port flags  output  4  {N,Z,C,V}, registered with result.
REQ-016 SHALL have port LED  output  LED_W  result[LED_W-1:0] of last completed op.

Function
REQ-017 SHALL implement FSM states IDLE, MUL, DONE; in_ready = (state==IDLE).
REQ-018 SHALL accept a request on in_valid&&in_ready, latching opA (acc if acc_mode else A), B, ctrl.
REQ-019 SHALL decode ctrl: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
REQ-020 SHALL compute non-MUL ops on accept edge, go IDLE->DONE; out_valid high the cycle after accept (latency 1).
REQ-021 SHALL compute MUL by shift-add, one bit per cycle, WIDTH cycles in MUL; out_valid high WIDTH+1 cycles after accept.
REQ-022 SHALL truncate all results to WIDTH bits; shift amount = B[log2(WIDTH)-1:0].
REQ-023 SHALL set Z = (result==0), N = result[WIDTH-1] for every op.
REQ-024 SHALL set C: ADD carry-out; SUB borrow (opA<B unsigned); SHL/SHR last bit shifted out (0 if amount 0); MUL 1 if upper WIDTH product bits nonzero; logic ops 0.
REQ-025 SHALL set V = signed overflow for ADD/SUB, 0 otherwise.
REQ-026 SHALL hold out_valid, result, flags stable in DONE until out_ready; on out_valid&&out_ready go IDLE (in_ready 1 next cycle), out_valid 0.
REQ-027 SHALL ignore in_valid while not IDLE (no queuing); min throughput one op per 2 cycles.
REQ-028 SHALL update accumulator with result on output handshake only; acc_mode sampled at accept.
REQ-029 SHALL update LED when DONE is entered; LED holds value through IDLE.

Reset
REQ-030 SHALL on rising clk with rst_n=0: state IDLE, out_valid 0, result 0, flags 0, LED 0, accumulator 0, MUL counter 0.
REQ-031 SHALL abort any in-flight MUL or pending DONE on reset; no result delivered.
REQ-032 SHALL assert in_ready the first cycle after rst_n returns high.

Verification (WIDTH=8, LED_W=4)
REQ-033 SHALL cover ADD 0x7F+0x01 -> result 0x80, flags N=1 Z=0 C=0 V=1, out_valid 1 cycle after accept, LED 0x0.
REQ-034 SHALL cover SUB 0x05-0x06 -> result 0xFF, N=1 Z=0 C=1 V=0; AND 0xAA&0x55 -> 0x00, Z=1.
REQ-035 SHALL cover MUL 0x10*0x11 -> result 0x10, C=1, out_valid exactly 9 cycles after accept, in_ready 0 throughout.
REQ-036 SHALL cover backpressure: out_ready=0 for 5 cycles with in_valid=1 -> result/flags stable, in_ready 0, second request accepted only after handshake.
REQ-037 SHALL cover accumulator: acc_mode=1, ADD B=0x03 three times (out_ready=1) -> results 0x03, 0x06, 0x09.
REQ-038 SHALL cover reset mid-MUL: rst_n=0 on 4th MUL cycle -> next edge out_valid 0, result 0, flags 0, LED 0; in_ready 1 after release; acc_mode ADD B=1 then gives 0x01.
